// File: rtl/fifo_rd_path.sv
// fifo_rd_path: read side of the streaming FIFO. It holds the buffer memory,
// resynchronizes the Gray write pointer, tracks the read pointer, and drives a
// registered valid/ready output stage.
module fifo_rd_path #(
  parameter int unsigned ADDR_WDTH    = 4,
  parameter int unsigned DATA_WDTH    = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter string       SYNC_EMPTY_N = "TRUE"
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  input  logic                 wr_en,
  input  logic [ADDR_WDTH-1:0] wr_addr,
  input  logic [DATA_WDTH-1:0] wr_din,
  input  logic [ADDR_WDTH:0]   wr_ptr_gray,
  input  logic                 rd_en,
  output logic [DATA_WDTH-1:0] rd_dout,
  output logic                 rd_dout_val,
  output logic [ADDR_WDTH:0]   rd_ptr_bin,
  output logic [ADDR_WDTH:0]   rd_ptr_gray,
  output logic                 empty_n
);

  localparam int unsigned PTR_W = ADDR_WDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WDTH;

  // Elaboration-time parameter legality
  if (!(DATA_WDTH == 8 || DATA_WDTH == 16 || DATA_WDTH == 32 || DATA_WDTH == 64)) begin : g_bad_data_wdth
    $fatal(1, "fifo_rd_path: DATA_WDTH must be 8, 16, 32 or 64");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $fatal(1, "fifo_rd_path: SYNC_STAGES must be at least 2");
  end

  logic [DATA_WDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_sync [SYNC_STAGES];
  logic [PTR_W-1:0]     r_rd_ptr_bin;
  logic [PTR_W-1:0]     r_rd_ptr_gray;
  logic [DATA_WDTH-1:0] r_rd_dout;
  logic                 r_rd_dout_val;

  logic [PTR_W-1:0]     w_wr_sync;
  logic [PTR_W-1:0]     w_wr_sync_nxt;
  logic                 w_ne;
  logic                 w_fetch;
  logic [PTR_W-1:0]     w_bin_nxt;
  logic [PTR_W-1:0]     w_gray_nxt;

  assign w_wr_sync     = r_sync[SYNC_STAGES-1];
  assign w_wr_sync_nxt = r_sync[SYNC_STAGES-2];
  assign w_ne          = (r_rd_ptr_gray != w_wr_sync);
  assign w_fetch       = w_ne & (~r_rd_dout_val | rd_en);
  assign w_bin_nxt     = r_rd_ptr_bin + PTR_W'(1);
  assign w_gray_nxt    = w_bin_nxt ^ (w_bin_nxt >> 1);

  // Buffer memory write port; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_din;
    end
  end

  // Plain flop chain resynchronizing the write-side Gray pointer
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= wr_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Output stage: load on fetch, hold under backpressure, drop valid when drained
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_rd_ptr_bin  <= '0;
      r_rd_ptr_gray <= '0;
      r_rd_dout     <= '0;
      r_rd_dout_val <= 1'b0;
    end else if (w_fetch) begin
      r_rd_dout     <= r_mem[r_rd_ptr_bin[ADDR_WDTH-1:0]];
      r_rd_dout_val <= 1'b1;
      r_rd_ptr_bin  <= w_bin_nxt;
      r_rd_ptr_gray <= w_gray_nxt;
    end else if (r_rd_dout_val && rd_en) begin
      r_rd_dout_val <= 1'b0;
    end
  end

  assign rd_dout     = r_rd_dout;
  assign rd_dout_val = r_rd_dout_val;
  assign rd_ptr_bin  = r_rd_ptr_bin;
  assign rd_ptr_gray = r_rd_ptr_gray;

  if (SYNC_EMPTY_N == "TRUE") begin : g_empty_reg
    logic             r_empty_n;
    logic [PTR_W-1:0] w_rd_gray_post;
    logic             w_ne_post;

    // Registered status tracks ne as it will stand after this edge
    assign w_rd_gray_post = w_fetch ? w_gray_nxt : r_rd_ptr_gray;
    assign w_ne_post      = (w_rd_gray_post != w_wr_sync_nxt);

    // Registered non-empty flag
    always_ff @(posedge clk) begin
      if (sync_rst) begin
        r_empty_n <= 1'b0;
      end else begin
        r_empty_n <= w_ne_post;
      end
    end

    assign empty_n = r_empty_n;
  end else if (SYNC_EMPTY_N == "FALSE") begin : g_empty_comb
    logic w_unused_sync_nxt;
    assign w_unused_sync_nxt = ^w_wr_sync_nxt;
    assign empty_n = w_ne | (w_unused_sync_nxt & 1'b0);
  end else begin : g_bad_sync_empty_n
    $fatal(1, "fifo_rd_path: SYNC_EMPTY_N must be \"TRUE\" or \"FALSE\"");
  end

endmodule

// File: tb/tb_fifo_rd_path.sv
// Directed bench for fifo_rd_path: reset, single word, burst, backpressure,
// pointer wrap, and a 64-bit instance with combinational empty_n.
module tb_fifo_rd_path;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_din;
  logic [4:0]  wr_ptr_gray;
  logic        rd_en;
  logic [7:0]  rd_dout;
  logic        rd_dout_val;
  logic [4:0]  rd_ptr_bin;
  logic [4:0]  rd_ptr_gray;
  logic        empty_n;

  logic        wr_en64;
  logic [3:0]  wr_addr64;
  logic [63:0] wr_din64;
  logic [4:0]  wr_gray64;
  logic        rd_en64;
  logic [63:0] rd_dout64;
  logic        val64;
  logic [4:0]  bin64;
  logic [4:0]  gray64;
  logic        empty_n64;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fifo_rd_path #(.ADDR_WDTH(4), .DATA_WDTH(8), .SYNC_STAGES(2), .SYNC_EMPTY_N("TRUE")) u_dut (
    .clk(clk), .sync_rst(sync_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
    .wr_ptr_gray(wr_ptr_gray), .rd_en(rd_en), .rd_dout(rd_dout), .rd_dout_val(rd_dout_val),
    .rd_ptr_bin(rd_ptr_bin), .rd_ptr_gray(rd_ptr_gray), .empty_n(empty_n)
  );

  fifo_rd_path #(.ADDR_WDTH(4), .DATA_WDTH(64), .SYNC_STAGES(2), .SYNC_EMPTY_N("FALSE")) u_dut64 (
    .clk(clk), .sync_rst(sync_rst), .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_din(wr_din64),
    .wr_ptr_gray(wr_gray64), .rd_en(rd_en64), .rd_dout(rd_dout64), .rd_dout_val(val64),
    .rd_ptr_bin(bin64), .rd_ptr_gray(gray64), .empty_n(empty_n64)
  );

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sync_rst    = 1'b1;
    wr_ptr_gray = '0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    step(1);
    sync_rst    = 1'b0;
  endtask

  logic [4:0] wp;
  logic [7:0] cur;
  logic [7:0] q[$];
  logic [7:0] exp_w;
  int         written;
  int         received;

  initial begin
    sync_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_din = '0;
    wr_ptr_gray = 5'b00011; rd_en = 1'b0;
    wr_en64 = 1'b0; wr_addr64 = '0; wr_din64 = '0; wr_gray64 = '0; rd_en64 = 1'b0;

    // Reset held two cycles with a nonzero incoming pointer
    step(1);
    chk("rst_val_0", 64'(rd_dout_val), 64'(0));
    chk("rst_gray_0", 64'(rd_ptr_gray), 64'(0));
    chk("rst_empty_0", 64'(empty_n), 64'(0));
    step(1);
    chk("rst_val_1", 64'(rd_dout_val), 64'(0));
    sync_rst = 1'b0;
    step(1);
    chk("rst_rel_val", 64'(rd_dout_val), 64'(0));
    chk("rst_rel_gray", 64'(rd_ptr_gray), 64'(0));
    chk("rst_rel_empty", 64'(empty_n), 64'(0));
    do_reset();

    // Single word with latency and hold
    wr_en = 1'b1; wr_addr = 4'd0; wr_din = 8'hA5;
    step(1);
    wr_en = 1'b0; wr_ptr_gray = g5(5'd1);
    step(1);
    chk("single_e0_val", 64'(rd_dout_val), 64'(0));
    chk("single_e0_empty", 64'(empty_n), 64'(0));
    step(1);
    chk("single_e1_val", 64'(rd_dout_val), 64'(0));
    chk("single_e1_empty", 64'(empty_n), 64'(1));
    step(1);
    chk("single_e2_val", 64'(rd_dout_val), 64'(1));
    chk("single_e2_data", 64'(rd_dout), 64'(8'hA5));
    chk("single_e2_empty", 64'(empty_n), 64'(0));
    step(2);
    chk("single_hold_val", 64'(rd_dout_val), 64'(1));
    chk("single_hold_data", 64'(rd_dout), 64'(8'hA5));
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("single_drop_val", 64'(rd_dout_val), 64'(0));
    chk("single_drop_gray", 64'(rd_ptr_gray), 64'(1));
    chk("single_drop_empty", 64'(empty_n), 64'(0));

    // Burst through all 16 slots at full rate
    do_reset();
    wp = '0;
    rd_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        wr_en = 1'b1; wr_addr = 4'(c); wr_din = 8'(c + 1);
        wp = wp + 5'd1; wr_ptr_gray = g5(wp);
      end else begin
        wr_en = 1'b0;
      end
      step(1);
      if (c < 2) chk("burst_pre_val", 64'(rd_dout_val), 64'(0));
      if (c >= 2 && c <= 17) begin
        chk("burst_val", 64'(rd_dout_val), 64'(1));
        chk("burst_data", 64'(rd_dout), 64'(c - 1));
      end
      if (c == 17) begin
        chk("burst_bin", 64'(rd_ptr_bin), 64'(16));
        chk("burst_gray", 64'(rd_ptr_gray), 64'(5'b11000));
      end
      if (c == 18) begin
        chk("burst_end_val", 64'(rd_dout_val), 64'(0));
        chk("burst_end_empty", 64'(empty_n), 64'(0));
      end
    end

    // Backpressure: four queued words, rd_en toggling
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = wp[3:0]; wr_din = 8'(8'h21 + i);
      wp = wp + 5'd1; wr_ptr_gray = g5(wp);
      step(1);
    end
    wr_en = 1'b0;
    step(3);
    chk("bp_first_val", 64'(rd_dout_val), 64'(1));
    chk("bp_first_empty", 64'(empty_n), 64'(1));
    cur = 8'h21;
    for (int j = 0; j < 8; j++) begin
      if (cur <= 8'h24) begin
        chk("bp_val", 64'(rd_dout_val), 64'(1));
        chk("bp_data", 64'(rd_dout), 64'(cur));
      end else begin
        chk("bp_done_val", 64'(rd_dout_val), 64'(0));
      end
      rd_en = ((j % 2) == 0);
      step(1);
      if ((j % 2) == 0) cur = cur + 8'd1;
    end
    rd_en = 1'b0;
    chk("bp_bin", 64'(rd_ptr_bin), 64'(20));
    chk("bp_empty", 64'(empty_n), 64'(0));

    // Interleaved traffic across address wrap and pointer wrap 31 -> 0
    written = 0; received = 0;
    for (int k = 0; k < 100; k++) begin
      rd_en = ((k % 5) != 4);
      if (rd_dout_val && rd_en) begin
        chk("wrap_nonempty_q", 64'(q.size() > 0), 64'(1));
        exp_w = (q.size() > 0) ? q.pop_front() : 8'h00;
        chk("wrap_data", 64'(rd_dout), 64'(exp_w));
        received++;
      end
      if (written < 40 && (k % 4) != 3) begin
        wr_en = 1'b1; wr_addr = wp[3:0]; wr_din = 8'(8'h40 + written);
        q.push_back(8'(8'h40 + written));
        wp = wp + 5'd1; wr_ptr_gray = g5(wp);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      step(1);
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk("wrap_count", 64'(received), 64'(40));
    chk("wrap_bin", 64'(rd_ptr_bin), 64'(28));
    chk("wrap_val", 64'(rd_dout_val), 64'(0));
    chk("wrap_empty", 64'(empty_n), 64'(0));

    // 64-bit word integrity with combinational empty_n
    wr_en64 = 1'b1; wr_addr64 = 4'd0; wr_din64 = 64'hDEADBEEF_CAFEF00D;
    step(1);
    wr_en64 = 1'b0; wr_gray64 = g5(5'd1);
    step(1);
    chk("w64_e0_empty", 64'(empty_n64), 64'(0));
    step(1);
    chk("w64_e1_empty", 64'(empty_n64), 64'(1));
    chk("w64_e1_val", 64'(val64), 64'(0));
    step(1);
    chk("w64_e2_val", 64'(val64), 64'(1));
    chk("w64_e2_data", rd_dout64, 64'hDEADBEEF_CAFEF00D);
    chk("w64_e2_bin", 64'(bin64), 64'(1));
    chk("w64_e2_gray", 64'(gray64), 64'(1));
    chk("w64_e2_empty", 64'(empty_n64), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
